// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: requester count and
// the two-state controller encoding.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux4to1.sv
// Plain N-bit 4:1 multiplexer used as the shared datapath of the arbiter.
module mux4to1 #(
    parameter int N = 8
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic [1:0]   sel,
    output logic [N-1:0] y
);

    // Route the selected input straight through to the output
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N-bit 4:1 datapath among four requesters.
// A grant is held until its owner drops req or has used MAX_HOLD cycles while
// someone else waits. Defining RR_MUX_ARBITER_STATS_EN adds a grant_count
// output with four 8-bit saturating per-requester grant counters.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = 4,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [N-1:0]       D0,
    input  logic [N-1:0]       D1,
    input  logic [N-1:0]       D2,
    input  logic [N-1:0]       D3,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         sel,
    output logic               busy,
    output logic [N-1:0]       out,
    output logic               out_valid
`ifdef RR_MUX_ARBITER_STATS_EN
    ,
    output logic [31:0]        grant_count
`endif
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    // Scan ptr+1, ptr+2, ptr+3, ptr and return {found, index} of the first
    // set bit. Walking backwards lets the highest-priority slot write last.
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                           input logic [1:0]         ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               drop;
    logic               expire;
    logic [NUM_REQ-1:0] others;
    logic [2:0]         pick;
    logic               new_grant;
    logic [N-1:0]       mux_y;

    // Next-state logic: start a grant from IDLE, hold or hand over in GRANT
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        pick      = 3'b000;
        new_grant = 1'b0;
        others    = req & ~grant_q;
        drop      = !req[sel_q];
        expire    = (cnt_q == CNT_MAX) && (|others);
        case (state_q)
            ST_IDLE: begin
                pick      = rr_pick(req, ptr_q);
                new_grant = pick[2];
            end
            ST_GRANT: begin
                if (drop || expire) begin
                    pick = rr_pick(others, ptr_q);
                    if (pick[2]) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        if (new_grant) begin
            state_d = ST_GRANT;
            grant_d = NUM_REQ'(1) << pick[1:0];
            sel_d   = pick[1:0];
            ptr_d   = pick[1:0];
            cnt_d   = '0;
        end
    end

    // Controller registers; ptr=3 after reset so the first search starts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    mux4to1 #(.N(N)) u_mux (
        .d0  (D0),
        .d1  (D1),
        .d2  (D2),
        .d3  (D3),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign busy      = (state_q == ST_GRANT);
    assign out       = busy ? mux_y : '0;
    assign out_valid = busy & req[sel_q];

`ifdef RR_MUX_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][7:0] gc_q, gc_d;

    // Count each new grant per requester, sticking at 255
    always_comb begin
        gc_d = gc_q;
        if (new_grant && (gc_q[pick[1:0]] != 8'hFF)) begin
            gc_d[pick[1:0]] = gc_q[pick[1:0]] + 8'd1;
        end
    end

    // Grant statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gc_q <= '0;
        end else begin
            gc_q <= gc_d;
        end
    end

    assign grant_count = gc_q;
`endif

endmodule
